// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchroniser + per-channel debounce FSM, level, rise/fall pulses, sticky press flag.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES+1 clk from stable input edge; no backpressure, press_ack clears press_pend.
module btn_debounce_pulse #(
   parameter int N_BTN           = 3,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_WIDTH       = 20,
   parameter int SYNC_STAGES     = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_in,
   input  logic [N_BTN-1:0] press_ack,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_rise,
   output logic [N_BTN-1:0] btn_fall,
   output logic [N_BTN-1:0] press_pend
);

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic [SYNC_STAGES-1:0][N_BTN-1:0] sync_q;
   logic [SYNC_STAGES-1:0][N_BTN-1:0] sync_d;
   logic [N_BTN-1:0]                  s;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      state_t               state_q, state_d;
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
      logic                 rise_q, rise_d;
      logic                 fall_q, fall_d;
      logic                 pend_q, pend_d;

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         rise_d  = 1'b0;
         fall_d  = 1'b0;
         case (state_q)
            ZERO: begin
               if (s[i]) begin
                  state_d = WAIT1;
                  cnt_d   = '0;
               end
            end
            WAIT1: begin
               if (!s[i]) begin
                  state_d = ZERO;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ONE;
                  rise_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ONE: begin
               if (!s[i]) begin
                  state_d = WAIT0;
                  cnt_d   = '0;
               end
            end
            WAIT0: begin
               if (s[i]) begin
                  state_d = ONE;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ZERO;
                  fall_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ZERO;
            end
         endcase
         // A rise in the same cycle as an ack wins, so no press is ever lost.
         pend_d = rise_q | (pend_q & ~press_ack[i]);
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= ZERO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            pend_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pend_q  <= pend_d;
         end
      end

      assign btn_level[i]  = (state_q == ONE) || (state_q == WAIT0);
      assign btn_rise[i]   = rise_q;
      assign btn_fall[i]   = fall_q;
      assign press_pend[i] = pend_q;
   end

endmodule
